// File: rtl/ascii_num_parser_if.sv
// Byte-in / result-out handshake bundle for the ASCII decimal parser.
interface ascii_num_parser_if #(
    parameter int unsigned WIDTH = 12
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic             num_err;
    logic             num_valid;
    logic             num_ready;

    // Byte producer and result consumer side
    modport master (
        output in_data, in_valid, num_ready,
        input  in_ready, num, num_err, num_valid
    );

    // Parser side
    modport slave (
        input  in_data, in_valid, num_ready,
        output in_ready, num, num_err, num_valid
    );
endinterface

// File: rtl/ascii_num_parser.sv
// ASCII decimal string to binary converter: digits accumulate until a
// terminator (CR, LF or ','), then one result word is offered with an error flag.
module ascii_num_parser #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned MAX_VALUE  = 4095
) (
    input  logic               clk,
    input  logic               reset_n,
    ascii_num_parser_if.slave  bus
);
    localparam int unsigned AW = WIDTH + 4;
    localparam int unsigned NW = $clog2(MAX_DIGITS + 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCUM   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_OUTPUT  = 2'd3;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [NW-1:0]    ndig, ndig_nx;
    logic [WIDTH-1:0] num_q, num_nx;
    logic             err_q, err_nx;
    logic             valid_q, valid_nx;
    logic             rdy_q, rdy_nx;

    logic             take;
    logic             is_digit;
    logic             is_term;
    logic [3:0]       dval;
    logic [AW-1:0]    prod;
    logic [NW:0]      ndig_inc;
    logic             overflow;

    // Byte classification and widened accumulate/overflow arithmetic
    always_comb begin
        take     = bus.in_valid & rdy_q;
        is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
        is_term  = (bus.in_data == 8'h0D) || (bus.in_data == 8'h0A) || (bus.in_data == 8'h2C);
        dval     = bus.in_data[3:0];
        prod     = AW'(acc) * AW'(4'd10) + AW'(dval);
        ndig_inc = (NW+1)'(ndig) + (NW+1)'(1);
        overflow = (ndig_inc > (NW+1)'(MAX_DIGITS)) || (prod > AW'(MAX_VALUE));
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        ndig_nx  = ndig;
        num_nx   = num_q;
        err_nx   = err_q;
        valid_nx = 1'b0;

        case (state)
            S_IDLE: begin
                if (take) begin
                    if (is_digit) begin
                        if (AW'(dval) > AW'(MAX_VALUE)) begin
                            state_nx = S_DISCARD;
                        end else begin
                            acc_nx   = WIDTH'(dval);
                            ndig_nx  = NW'(1);
                            state_nx = S_ACCUM;
                        end
                    end else if (!is_term) begin
                        state_nx = S_DISCARD;
                    end
                end
            end
            S_ACCUM: begin
                if (take) begin
                    if (is_digit) begin
                        if (overflow) begin
                            state_nx = S_DISCARD;
                        end else begin
                            acc_nx  = WIDTH'(prod);
                            ndig_nx = NW'(ndig_inc);
                        end
                    end else if (is_term) begin
                        num_nx   = acc;
                        err_nx   = 1'b0;
                        state_nx = S_OUTPUT;
                    end else begin
                        state_nx = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (take && is_term) begin
                    num_nx   = '0;
                    err_nx   = 1'b1;
                    state_nx = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                valid_nx = 1'b1;
                if (valid_q && bus.num_ready) begin
                    valid_nx = 1'b0;
                    acc_nx   = '0;
                    ndig_nx  = '0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Hold off input on entry to OUTPUT and for one cycle after the result is taken
        rdy_nx = (state_nx != S_OUTPUT) && (state != S_OUTPUT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            ndig    <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            ndig    <= ndig_nx;
            num_q   <= num_nx;
            err_q   <= err_nx;
            valid_q <= valid_nx;
            rdy_q   <= rdy_nx;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.num       = num_q;
    assign bus.num_err   = err_q;
    assign bus.num_valid = valid_q;
endmodule

// File: tb/tb_ascii_num_parser.sv
// Directed bench for ascii_num_parser: vector table plus multi-cycle corner sequences.
module tb_ascii_num_parser;
    localparam int unsigned WIDTH = 12;
    localparam int NV = 11;

    typedef struct {
        string       s;
        int unsigned exp_num;
        int unsigned exp_err;
    } vec_t;

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] num;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ascii_num_parser_if #(.WIDTH(WIDTH)) bus();

    ascii_num_parser #(
        .WIDTH(WIDTH),
        .MAX_DIGITS(4),
        .MAX_VALUE(4095)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    res_t        results[$];
    int          valid_seen = 0;
    int unsigned rise_cyc = 0;
    logic        valid_prev = 1'b0;
    logic        bg_done = 1'b0;

    // Edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor, sampled mid-cycle; a handshake completes at the following edge
    always @(negedge clk) begin
        if (bus.num_valid) valid_seen <= valid_seen + 1;
        if (bus.num_valid && !valid_prev) rise_cyc <= cyc;
        valid_prev <= bus.num_valid;
        if (bus.num_valid && bus.num_ready && reset_n) results.push_back({bus.num_err, bus.num});
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: byte 0x%02h got no in_ready expected in_ready=1", b);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            send_byte(s[i]);
        end
    endtask

    task automatic wait_results(input int n, input string name);
        int k = 0;
        while (results.size() < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (results.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: got %0d results expected %0d", name, results.size(), n);
        end
    endtask

    task automatic expect_result(input string name, input int unsigned en, input int unsigned ee);
        res_t r;
        if (results.size() > 0) begin
            r = results.pop_front();
            check({name, "_num"}, 32'(r.num), en);
            check({name, "_err"}, 32'(r.err), ee);
        end
    endtask

    // Hard stop in case something wedges
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[NV];
        int unsigned term_cyc;
        int          vs;

        vecs[0]  = '{"123\r",   123,  0};
        vecs[1]  = '{"4095\n",  4095, 0};
        vecs[2]  = '{"4096\n",  0,    1};
        vecs[3]  = '{"00007\n", 0,    1};
        vecs[4]  = '{"12a3,",   0,    1};
        vecs[5]  = '{"9,",      9,    0};
        vecs[6]  = '{"0000\r",  0,    0};
        vecs[7]  = '{"abc\n",   0,    1};
        vecs[8]  = '{"99999,",  0,    1};
        vecs[9]  = '{"7\r\n",   7,    0};
        vecs[10] = '{"0042\n",  42,   0};

        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.num_ready = 1'b1;
        reset_n       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  0);
        check("rst_num_valid", 32'(bus.num_valid), 0);
        check("rst_num",       32'(bus.num),       0);
        check("rst_num_err",   32'(bus.num_err),   0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(bus.in_ready), 1);

        // Table-driven vectors, consumer always ready
        for (int i = 0; i < NV; i++) begin
            send_str(vecs[i].s, 1'b0);
            term_cyc = cyc;
            wait_results(1, $sformatf("vec%0d", i));
            if (i == 0) check("latency_cr_to_valid", rise_cyc - term_cyc, 1);
            expect_result($sformatf("vec%0d", i), vecs[i].exp_num, vecs[i].exp_err);
        end
        repeat (5) @(posedge clk);
        #1;
        check("table_no_extra", 32'(results.size()), 0);

        // Empty fields never produce a result and never stall input
        vs = valid_seen;
        send_byte(8'h0D);
        check("empty_rdy0", 32'(bus.in_ready), 1);
        send_byte(8'h0A);
        check("empty_rdy1", 32'(bus.in_ready), 1);
        send_byte(8'h2C);
        check("empty_rdy2", 32'(bus.in_ready), 1);
        send_byte(8'h0D);
        repeat (4) @(posedge clk);
        #1;
        check("empty_rdy3", 32'(bus.in_ready), 1);
        check("empty_no_valid", 32'(valid_seen - vs), 0);
        check("empty_no_result", 32'(results.size()), 0);

        // Back-to-back results with the consumer stalled
        bus.num_ready = 1'b0;
        bg_done = 1'b0;
        fork
            begin
                send_str("5,6,", 1'b0);
                bg_done = 1'b1;
            end
        join_none
        repeat (10) @(posedge clk);
        #1;
        check("hold_valid",    32'(bus.num_valid), 1);
        check("hold_num",      32'(bus.num),       5);
        check("hold_err",      32'(bus.num_err),   0);
        check("hold_in_ready", 32'(bus.in_ready),  0);
        check("hold_none_yet", 32'(results.size()), 0);
        bus.num_ready = 1'b1;
        wait_results(2, "b2b");
        expect_result("b2b_first", 5, 0);
        expect_result("b2b_second", 6, 0);
        for (int k = 0; k < 100 && !bg_done; k++) begin
            @(posedge clk);
            #1;
        end
        check("b2b_sender_done", 32'(bg_done), 1);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_exactly_two", 32'(results.size()), 0);

        // Reset mid-number discards the partial value
        send_str("12", 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("midrst_in_ready", 32'(bus.in_ready), 0);
        check("midrst_num_valid", 32'(bus.num_valid), 0);
        send_str("3\r", 1'b0);
        wait_results(1, "midrst");
        expect_result("midrst", 3, 0);

        // Idle gaps between bytes must not change the result
        send_str("2048\r", 1'b1);
        wait_results(1, "gap");
        expect_result("gap", 2048, 0);
        send_str("2048\r", 1'b0);
        wait_results(1, "nogap");
        expect_result("nogap", 2048, 0);

        repeat (5) @(posedge clk);
        #1;
        check("final_no_extra", 32'(results.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
